// File: rtl/risc_pkg.sv
// Shared definitions for the RISC fetch path: sequencer states, next-address
// select encodings and the reset vector.
package risc_pkg;

  localparam int unsigned PC_W_DEF = 10;
  localparam int unsigned FC_W     = 3;

  localparam logic [PC_W_DEF-1:0] RESET_VEC = 10'h000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_PC1  = 2'd0,
    SEL_BRA  = 2'd1,
    SEL_RAA  = 2'd2,
    SEL_BRA2 = 2'd3
  } sel_e;

endpackage

// File: rtl/next_addr_sel.sv
// Branch-condition evaluation and 4:1 next-address mux for the fetch path.
module next_addr_sel
  import risc_pkg::*;
#(
  parameter int unsigned PC_W = 10
) (
  input  logic [1:0]      bs,
  input  logic            ps,
  input  logic            z,
  input  logic [PC_W-1:0] bra,
  input  logic [PC_W-1:0] raa,
  input  logic [PC_W-1:0] pc_1,
  output sel_e            sel_c,
  output logic [PC_W-1:0] target_c
);

  // BS_one forces the jump; BS_zero alone branches on Z with polarity PS.
  assign sel_c = sel_e'({bs[1], bs[0] & (bs[1] | (ps ^ z))});

  always_comb begin
    target_c = pc_1;
    case (sel_c)
      SEL_PC1:  target_c = pc_1;
      SEL_BRA:  target_c = bra;
      SEL_RAA:  target_c = raa;
      SEL_BRA2: target_c = bra;
      default:  target_c = pc_1;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: owns the PC, takes execute-stage redirects,
// squashes wrong-path slots afterwards and counts taken redirects.
module pc_sequencer
  import risc_pkg::*;
#(
  parameter int unsigned     PC_W         = 10,
  parameter logic [PC_W-1:0] RESET_VEC    = PC_W'(risc_pkg::RESET_VEC),
  parameter int unsigned     FLUSH_CYCLES = 2,
  parameter int unsigned     CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [1:0]        BS,
  input  logic              PS,
  input  logic              Z,
  input  logic [PC_W-1:0]   BrA,
  input  logic [PC_W-1:0]   RAA,
  input  logic              br_valid,
  input  logic              stall,
  output logic [PC_W-1:0]   PC,
  output logic [PC_W-1:0]   PC_1,
  output logic              fetch_en,
  output logic              squash,
  output logic              redirect,
  output logic [CNT_W-1:0]  taken_cnt
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [FC_W-1:0]   flush_q, flush_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              redirect_q, redirect_d;

  sel_e              sel_c;
  logic [PC_W-1:0]   target_c;
  logic              taken_c;

  assign PC_1 = pc_q + PC_W'(1);

  next_addr_sel #(
    .PC_W (PC_W)
  ) u_next_addr_sel (
    .bs       (BS),
    .ps       (PS),
    .z        (Z),
    .bra      (BrA),
    .raa      (RAA),
    .pc_1     (PC_1),
    .sel_c    (sel_c),
    .target_c (target_c)
  );

  assign taken_c = br_valid && (sel_c != SEL_PC1) && (state_q == RUN);

  // Next-state, next-PC and state-decoded fetch controls.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = flush_q;
    cnt_d      = cnt_q;
    redirect_d = redirect_q;
    fetch_en   = 1'b0;
    squash     = 1'b0;

    case (state_q)
      BOOT:  ;
      RUN:   fetch_en = 1'b1;
      FLUSH: begin
        fetch_en = 1'b1;
        squash   = 1'b1;
      end
      default: ;
    endcase

    if (!stall) begin
      redirect_d = 1'b0;
      case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (taken_c) begin
            pc_d       = target_c;
            flush_d    = FC_W'(FLUSH_CYCLES);
            redirect_d = 1'b1;
            state_d    = FLUSH;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            pc_d = PC_1;
          end
        end
        FLUSH: begin
          // br_valid here belongs to a wrong-path instruction.
          pc_d = PC_1;
          if (flush_q <= FC_W'(1)) begin
            flush_d = '0;
            state_d = RUN;
          end else begin
            flush_d = flush_q - FC_W'(1);
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      flush_q    <= '0;
      cnt_q      <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
    end
  end

  assign PC        = pc_q;
  assign redirect  = redirect_q;
  assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a second narrow-counter instance
// exercises taken_cnt saturation within a short run.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic [1:0]  bs;
  logic        ps;
  logic        z;
  logic [9:0]  bra;
  logic [9:0]  raa;
  logic        br_valid;
  logic        stall;

  logic [9:0]  pc, pc_1;
  logic        fetch_en, squash, redirect;
  logic [15:0] taken_cnt;

  logic [9:0]  s_pc, s_pc_1;
  logic        s_fetch_en, s_squash, s_redirect;
  logic [3:0]  s_taken_cnt;

  int total = 0;
  int bad   = 0;

  pc_sequencer dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .BS        (bs),
    .PS        (ps),
    .Z         (z),
    .BrA       (bra),
    .RAA       (raa),
    .br_valid  (br_valid),
    .stall     (stall),
    .PC        (pc),
    .PC_1      (pc_1),
    .fetch_en  (fetch_en),
    .squash    (squash),
    .redirect  (redirect),
    .taken_cnt (taken_cnt)
  );

  pc_sequencer #(.CNT_W(4)) u_sat (
    .CLK       (clk),
    .RST_N     (rst_n),
    .BS        (bs),
    .PS        (ps),
    .Z         (z),
    .BrA       (bra),
    .RAA       (raa),
    .br_valid  (br_valid),
    .stall     (stall),
    .PC        (s_pc),
    .PC_1      (s_pc_1),
    .fetch_en  (s_fetch_en),
    .squash    (s_squash),
    .redirect  (s_redirect),
    .taken_cnt (s_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic [9:0] e_pc, input logic e_fe,
                         input logic e_sq, input logic e_rd, input logic [15:0] e_cnt);
    chk({tag, ".pc"},       32'(pc),        32'(e_pc));
    chk({tag, ".fetch_en"}, 32'(fetch_en),  32'(e_fe));
    chk({tag, ".squash"},   32'(squash),    32'(e_sq));
    chk({tag, ".redirect"}, 32'(redirect),  32'(e_rd));
    chk({tag, ".taken"},    32'(taken_cnt), 32'(e_cnt));
  endtask

  initial begin
    rst_n = 1'b0; bs = 2'b00; ps = 1'b0; z = 1'b0;
    bra = '0; raa = '0; br_valid = 1'b0; stall = 1'b0;

    step();
    chk_all("reset", 10'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("reset.pc_1", 32'(pc_1), 32'h001);
    rst_n = 1'b1;
    chk("boot.fetch_en", 32'(fetch_en), 32'd0);

    // BOOT -> RUN, PC holds reset vector for the first fetch
    step(); chk_all("run0", 10'h000, 1'b1, 1'b0, 1'b0, 16'd0);
    step(); chk_all("run1", 10'h001, 1'b1, 1'b0, 1'b0, 16'd0);
    step(); chk_all("run2", 10'h002, 1'b1, 1'b0, 1'b0, 16'd0);
    step(); step(); step();
    chk("run5.pc", 32'(pc), 32'h005);

    // Conditional branch taken: BS=01, PS^Z=1
    bs = 2'b01; ps = 1'b0; z = 1'b1; bra = 10'h120; br_valid = 1'b1;
    step(); chk_all("bra", 10'h120, 1'b1, 1'b1, 1'b1, 16'd1);
    br_valid = 1'b0;
    step(); chk_all("bra_f1", 10'h121, 1'b1, 1'b1, 1'b0, 16'd1);
    step(); chk_all("bra_f2", 10'h122, 1'b1, 1'b0, 1'b0, 16'd1);

    // Same branch with Z=0: not taken
    z = 1'b0; br_valid = 1'b1;
    step(); chk_all("bra_nt", 10'h123, 1'b1, 1'b0, 1'b0, 16'd1);

    // Register jump then PC wrap
    bs = 2'b10; raa = 10'h3FE;
    step(); chk_all("raa", 10'h3FE, 1'b1, 1'b1, 1'b1, 16'd2);
    br_valid = 1'b0;
    step(); chk_all("raa_f1", 10'h3FF, 1'b1, 1'b1, 1'b0, 16'd2);
    chk("wrap.pc_1", 32'(pc_1), 32'h000);
    step(); chk_all("wrap", 10'h000, 1'b1, 1'b0, 1'b0, 16'd2);

    // BS=11 always uses BrA; then a wrong-path branch during FLUSH
    bs = 2'b11; ps = 1'b1; z = 1'b1; bra = 10'h055; br_valid = 1'b1;
    step(); chk_all("bra2", 10'h055, 1'b1, 1'b1, 1'b1, 16'd3);
    bs = 2'b10; raa = 10'h200;
    step(); chk_all("wrongpath", 10'h056, 1'b1, 1'b1, 1'b0, 16'd3);
    br_valid = 1'b0;
    step(); chk_all("wp_done", 10'h057, 1'b1, 1'b0, 1'b0, 16'd3);

    // Taken branch held under stall for 3 cycles
    bs = 2'b01; ps = 1'b1; z = 1'b0; bra = 10'h2AA; br_valid = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("stall_run", 10'h057, 1'b1, 1'b0, 1'b0, 16'd3);
    end
    stall = 1'b0;
    step(); chk_all("stall_rel", 10'h2AA, 1'b1, 1'b1, 1'b1, 16'd4);

    // Stall in the redirect cycle holds redirect and stretches squash
    br_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("stall_fl", 10'h2AA, 1'b1, 1'b1, 1'b1, 16'd4);
    end
    stall = 1'b0;
    step(); chk_all("fl_rel1", 10'h2AB, 1'b1, 1'b1, 1'b0, 16'd4);
    step(); chk_all("fl_rel2", 10'h2AC, 1'b1, 1'b0, 1'b0, 16'd4);

    // Asynchronous reset in the middle of FLUSH
    bs = 2'b10; raa = 10'h010; br_valid = 1'b1;
    step(); chk_all("pre_rst", 10'h010, 1'b1, 1'b1, 1'b1, 16'd5);
    br_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 10'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    step(); rst_n = 1'b1;
    step(); chk_all("post_rst0", 10'h000, 1'b1, 1'b0, 1'b0, 16'd0);
    step(); chk_all("post_rst1", 10'h001, 1'b1, 1'b0, 1'b0, 16'd0);

    // Saturation: 15 branches fill the 4-bit counter, a 16th must not wrap
    bs = 2'b10; raa = 10'h100;
    for (int i = 0; i < 15; i++) begin
      br_valid = 1'b1; step();
      br_valid = 1'b0; step(); step();
    end
    chk("sat15.narrow", 32'(s_taken_cnt), 32'hF);
    chk("sat15.wide",   32'(taken_cnt),   32'd15);
    br_valid = 1'b1; step();
    chk("sat16.narrow", 32'(s_taken_cnt), 32'hF);
    chk("sat16.wide",   32'(taken_cnt),   32'd16);
    chk("sat16.redirect", 32'(s_redirect), 32'd1);
    chk("sat16.pc",     32'(s_pc),        32'h100);
    br_valid = 1'b0; step(); step();
    chk("sat_end.squash", 32'(s_squash), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter controller for the RISC fetch path. It owns the PC register and evaluates the branch-select condition from the execute stage (BS, PS, Z) to choose between PC+1, the branch address and the register jump address. It squashes the wrong-path instructions after a taken redirect and counts taken redirects for debug. It sits between the execute stage and instruction memory, and replaces the free-standing next-address mux in the fetch loop.

## Interface
- `PC_W`, 10, PC and address width.
- `RESET_VEC`, 10'h000, PC value loaded on reset.
- `FLUSH_CYCLES`, 2, number of fetch slots squashed after a taken redirect (1..7).
- `CNT_W`, 16, width of the taken-redirect counter.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST_N`  in  1  reset, asynchronous and active-low.
- `BS`  in  2  branch select from execute: BS[1] is BS_one, BS[0] is BS_zero.
- `PS`  in  1  polarity select for the conditional branch.
- `Z`  in  1  zero flag from the ALU.
- `BrA`  in  PC_W  branch target address.
- `RAA`  in  PC_W  register jump address.
- `br_valid`  in  1  BS, PS, Z, BrA and RAA belong to a live execute-stage instruction.
- `stall`  in  1  freeze PC, FSM and counters this cycle.
- `PC`  out  PC_W  current fetch address (registered).
- `PC_1`  out  PC_W  PC+1, modulo 2^PC_W (combinational from PC).
- `fetch_en`  out  1  instruction memory read enable.
- `squash`  out  1  kill the instruction now in decode/execute.
- `redirect`  out  1  one-cycle pulse in the first cycle PC holds a redirect target.
- `taken_cnt`  out  CNT_W  saturating count of taken redirects.

## Operation
- Select: sel = {BS[1], BS[0] & (BS[1] | (PS ^ Z))}.
  - sel 0 → PC_1; sel 1 → BrA; sel 2 → RAA; sel 3 → BrA.
  - Redirect is taken when br_valid & (sel != 0) & state==RUN.
- FSM states:
  - BOOT: entered on reset. fetch_en=0, squash=0. Next edge with !stall → RUN.
  - RUN: fetch_en=1. Not taken: PC ← PC_1. Taken: PC ← target, flush counter ← FLUSH_CYCLES, redirect ← 1, taken_cnt += 1 (saturating at all-ones) → FLUSH.
  - FLUSH: fetch_en=1, squash=1, PC ← PC_1. br_valid is ignored because it belongs to a wrong-path instruction. The counter decrements each edge and returns to RUN when it reaches 1.
- stall=1: PC, state, flush counter, taken_cnt and redirect all hold. `squash` and `fetch_en` keep their state-derived values.
- A taken branch presented together with stall is not acted on. Upstream holds br_valid until stall drops.
- Width rules:
  - PC_1 wraps 0x3FF→0x000.
  - BrA and RAA are used unmodified.
  - taken_cnt never wraps.

## Timing
- Reset values: PC=RESET_VEC, state=BOOT, fetch_en=0, squash=0, redirect=0, taken_cnt=0, flush counter=0.
- Reset asserted mid-FLUSH or mid-stall takes effect immediately (asynchronous) and discards the pending flush.
- Redirect latency is 1 edge: the target appears on PC in the cycle after the taken br_valid edge, with redirect=1 and squash=1 in that same cycle.
- squash stays high for exactly FLUSH_CYCLES unstalled cycles. Stalled cycles extend it.
- redirect is high for exactly one cycle. If stall is asserted in that cycle, redirect holds until the next unstalled edge.
- PC_1 tracks PC combinationally with zero latency. All other outputs are registered or state-decoded only, with no combinational path from inputs to outputs.

## Structure
- Shared package `risc_pkg`: state enum (BOOT, RUN, FLUSH), the sel encodings (SEL_PC1=0, SEL_BRA=1, SEL_RAA=2, SEL_BRA2=3), and RESET_VEC.
- One natural sub-module, `next_addr_sel`: combinational sel computation plus the 4:1 target mux. It is instantiated once. The FSM, PC register and counters live in `pc_sequencer`.

## Test plan
- Reset release, stall=0, br_valid=0 → one BOOT cycle with PC=0x000 and fetch_en=0, then PC steps 0x000, 0x001, 0x002 with fetch_en=1.
- PC=0x005, BS=01, PS=0, Z=1, BrA=0x120, br_valid=1 → next cycle PC=0x120, redirect=1, squash=1 for 2 cycles, PC 0x121, 0x122, taken_cnt=1. Repeat with Z=0 → PC=0x006, no squash.
- BS=10, RAA=0x3FE → PC=0x3FE, then PC steps 0x3FF, 0x000 (wrap). BS=11 with any PS/Z → PC=BrA.
- Taken branch with stall=1 for 3 cycles → PC, taken_cnt and state frozen. On stall release, redirect on the next edge. A stall inserted during FLUSH extends squash by 3 cycles.
- br_valid taken during FLUSH (wrong-path) → ignored: PC continues PC+1 and taken_cnt is unchanged.
- RST_N pulsed low mid-FLUSH → all outputs return to reset values immediately. With taken_cnt preloaded to 0xFFFF via repeated branches, one more taken branch leaves it at 0xFFFF.
